cv_tmds_decoder: RTL and testbench

- Receive-side counterpart of the TMDS serialiser path; one instance per TMDS channel.
- Input: raw 10-bit parallel words from a 1:10 deserialiser. The word boundary is unknown.
- Finds the symbol boundary by searching the four TMDS control tokens, then decodes each symbol to 8-bit pixel data, or to 2-bit control plus a data-enable flag.
- Reports lock status and the selected bit offset to the capture logic.

---
 rtl/cv_tmds_decoder.sv | 154 +++++++++++++++
 tb/tb_cv_tmds_decoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cv_tmds_decoder.sv
// TMDS receive decoder: finds the symbol boundary from control tokens, decodes pixel/control symbols.
// Latency: 3 cycles din->outputs (prev, aligned, out), independent of offset.
// Backpressure: none; streaming at pixel rate. Optional err_cnt port via CV_TMDS_DECODER_ERRCNT_EN.
module cv_tmds_decoder #(
  parameter int LOCK_COUNT    = 16,
  parameter int SEARCH_WIN    = 2048,
  parameter int TOKEN_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] din,
  output logic [7:0] dout,
  output logic [1:0] ctl,
  output logic       de,
  output logic       locked,
  output logic [3:0] offset
`ifdef CV_TMDS_DECODER_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int TW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(SEARCH_WIN);
  localparam int IW = $clog2(TOKEN_TIMEOUT);
  localparam logic [TW-1:0] TOK_LAST  = TW'(LOCK_COUNT - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(SEARCH_WIN - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TOKEN_TIMEOUT - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t        state;
  logic [9:0]    prev;
  logic [9:0]    aligned;
  logic [19:0]   window;
  logic [TW-1:0] tok_run;
  logic [WW-1:0] win_cnt;
  logic [IW-1:0] idle_cnt;
  logic          tok_hit;
  logic [1:0]    tok_ctl;
  logic [7:0]    qi;
  logic [7:0]    data_dec;
  logic [3:0]    next_offset;
  logic          drop;

  // prev is the older word, so the low half of the window holds earlier bits
  assign window      = {din, prev};
  assign next_offset = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
  assign drop        = (state == LOCKED) && !tok_hit && (idle_cnt == IDLE_LAST);

  // Token match and TMDS data decode of the aligned symbol
  always_comb begin
    tok_hit = 1'b1;
    tok_ctl = 2'b00;
    case (aligned)
      10'b1101010100: tok_ctl = 2'b00;
      10'b0010101011: tok_ctl = 2'b01;
      10'b0101010100: tok_ctl = 2'b10;
      10'b1010101011: tok_ctl = 2'b11;
      default:        tok_hit = 1'b0;
    endcase
    qi          = aligned[9] ? ~aligned[7:0] : aligned[7:0];
    data_dec    = 8'd0;
    data_dec[0] = qi[0];
    for (int i = 1; i < 8; i++) begin
      data_dec[i] = aligned[8] ? (qi[i] ^ qi[i-1]) : ~(qi[i] ^ qi[i-1]);
    end
  end

  // Word capture and barrel-shift alignment
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev    <= 10'd0;
      aligned <= 10'd0;
    end else begin
      prev    <= din;
      aligned <= 10'(window >> offset);
    end
  end

  // Registered decode outputs; the unused field holds across symbol types
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout <= 8'd0;
      ctl  <= 2'b00;
      de   <= 1'b0;
    end else if (tok_hit) begin
      ctl <= tok_ctl;
      de  <= 1'b0;
    end else begin
      dout <= data_dec;
      de   <= 1'b1;
    end
  end

  // Alignment FSM: search offsets for a token run, drop lock on token starvation
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= SEARCH;
      locked   <= 1'b0;
      offset   <= 4'd0;
      tok_run  <= '0;
      win_cnt  <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        SEARCH: begin
          if (tok_hit && tok_run == TOK_LAST) begin
            // lock takes priority over a simultaneous window expiry
            state    <= LOCKED;
            locked   <= 1'b1;
            tok_run  <= '0;
            win_cnt  <= '0;
            idle_cnt <= '0;
          end else if (win_cnt == WIN_LAST) begin
            offset  <= next_offset;
            tok_run <= '0;
            win_cnt <= '0;
          end else begin
            win_cnt <= win_cnt + 1'b1;
            tok_run <= tok_hit ? tok_run + 1'b1 : '0;
          end
        end
        LOCKED: begin
          if (tok_hit) begin
            idle_cnt <= '0;
          end else if (drop) begin
            state    <= SEARCH;
            locked   <= 1'b0;
            offset   <= next_offset;
            tok_run  <= '0;
            win_cnt  <= '0;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

`ifdef CV_TMDS_DECODER_ERRCNT_EN
  // Saturating count of lock losses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_cnt <= 8'd0;
    end else if (drop && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cv_tmds_decoder.sv
// Directed bench for cv_tmds_decoder: lock, rotation search, data decode, token loss, wrap, async reset.
module tb_cv_tmds_decoder;

  localparam logic [9:0] T0 = 10'b1101010100;
  localparam logic [9:0] T1 = 10'b0010101011;
  localparam logic [9:0] T2 = 10'b0101010100;
  localparam logic [9:0] T3 = 10'b1010101011;

  logic       clk;
  logic       resetn;
  logic [9:0] din;
  logic [7:0] dout;
  logic [1:0] ctl;
  logic       de;
  logic       locked;
  logic [3:0] offset;
`ifdef CV_TMDS_DECODER_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int checks;
  int errors;
  logic [9:0] last_sym;

  cv_tmds_decoder dut (
    .clk    (clk),
    .resetn (resetn),
    .din    (din),
    .dout   (dout),
    .ctl    (ctl),
    .de     (de),
    .locked (locked),
    .offset (offset)
`ifdef CV_TMDS_DECODER_ERRCNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic is_token(input logic [9:0] w);
    return (w == T0) || (w == T1) || (w == T2) || (w == T3);
  endfunction

  // Present one symbol whose boundary sits r bits into the word, then advance one edge
  task automatic step(input logic [9:0] sym, input int r);
    logic [19:0] t;
    t        = {sym, last_sym};
    t        = t >> (10 - r);
    din      = t[9:0];
    last_sym = sym;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resetn   = 1'b0;
    din      = 10'd0;
    last_sym = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    resetn = 1'b0;
    #1;
    checks++; if (dout !== 8'd0)  begin errors++; $display("FAIL reset_dout got %h want 00", dout); end
    checks++; if (ctl !== 2'd0)   begin errors++; $display("FAIL reset_ctl got %h want 0", ctl); end
    checks++; if (de !== 1'b0)    begin errors++; $display("FAIL reset_de got %b want 0", de); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
    checks++; if (offset !== 4'd0) begin errors++; $display("FAIL reset_offset got %0d want 0", offset); end
    apply_reset();
  endtask

  task automatic test_aligned_lock();
    for (int n = 1; n <= 17; n++) step(T0, 0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early got %b want 0", locked); end
    step(T0, 0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_at18 got %b want 1", locked); end
    checks++; if (offset !== 4'd0) begin errors++; $display("FAIL lock_offset got %0d want 0", offset); end
    checks++; if (de !== 1'b0)     begin errors++; $display("FAIL lock_de got %b want 0", de); end
    checks++; if (ctl !== 2'b00)   begin errors++; $display("FAIL lock_ctl got %b want 00", ctl); end
  endtask

  task automatic test_data_decode();
    logic [9:0] enc [6];
    logic [7:0] exp [6];
    enc[0] = 10'h100; exp[0] = 8'h00;
    enc[1] = 10'h255; exp[1] = 8'h00;
    enc[2] = 10'h3AA; exp[2] = 8'hFF;
    enc[3] = 10'h0FF; exp[3] = 8'hFF;
    enc[4] = 10'h133; exp[4] = 8'h55;
    enc[5] = 10'h2A5; exp[5] = 8'h10;
    for (int i = 0; i < 8; i++) begin
      step((i < 6) ? enc[i] : T0, 0);
      if (i >= 2) begin
        checks++;
        if (dout !== exp[i-2] || de !== 1'b1) begin
          errors++; $display("FAIL data_%0d got dout=%h de=%b want dout=%h de=1", i-2, dout, de, exp[i-2]);
        end
      end
      if (i == 4) begin
        checks++; if (ctl !== 2'b00) begin errors++; $display("FAIL data_ctl_hold got %b want 00", ctl); end
      end
    end
    step(T0, 0);
    checks++;
    if (de !== 1'b0 || dout !== 8'h10) begin
      errors++; $display("FAIL data_dout_hold got dout=%h de=%b want dout=10 de=0", dout, de);
    end
    repeat (4) step(T0, 0);
  endtask

  task automatic test_token_loss();
    for (int n = 1; n <= 4097; n++) step(10'h100, 0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL loss_early got %b want 1", locked); end
    step(10'h100, 0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_drop got %b want 0", locked); end
    checks++; if (offset !== 4'd1) begin errors++; $display("FAIL loss_offset got %0d want 1", offset); end
`ifdef CV_TMDS_DECODER_ERRCNT_EN
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL loss_errcnt got %0d want 1", err_cnt); end
`endif
  endtask

  task automatic test_wrap();
    logic [9:0] w;
    logic       ever_locked;
    ever_locked = 1'b0;
    apply_reset();
    for (int n = 1; n <= 10 * 2048; n++) begin
      w = 10'($urandom);
      if (is_token(w)) w = 10'h100;
      step(w, 0);
      if (locked) ever_locked = 1'b1;
      if (n == 9 * 2048) begin
        checks++; if (offset !== 4'd9) begin errors++; $display("FAIL wrap_at9 got %0d want 9", offset); end
      end
      if (n == 10 * 2048 - 1) begin
        checks++; if (offset !== 4'd9) begin errors++; $display("FAIL wrap_hold9 got %0d want 9", offset); end
      end
    end
    checks++; if (offset !== 4'd0) begin errors++; $display("FAIL wrap_to0 got %0d want 0", offset); end
    checks++; if (ever_locked !== 1'b0) begin errors++; $display("FAIL wrap_nolock got %b want 0", ever_locked); end
  endtask

  task automatic test_rotated();
    logic [9:0] toks [4];
    int         n;
    int         k;
    logic [1:0] c;
    toks[0] = T0; toks[1] = T1; toks[2] = T2; toks[3] = T3;
    apply_reset();
    n = 0;
    k = 0;
    while (!locked && n < 7 * 2048 + 60) begin
      step(toks[n % 4], 7);
      n++;
      if (k < 7 && n == 2048 * k + 1000) begin
        checks++; if (offset !== 4'(k)) begin errors++; $display("FAIL rot_offset_%0d got %0d want %0d", k, offset, k); end
        k++;
      end
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rot_lock got %b want 1 after %0d cycles", locked, n); end
    checks++; if (offset !== 4'd7) begin errors++; $display("FAIL rot_lock_offset got %0d want 7", offset); end
    c = ctl;
    for (int i = 0; i < 4; i++) begin
      step(toks[n % 4], 7);
      n++;
      checks++;
      if (ctl !== c + 2'd1 || de !== 1'b0) begin
        errors++; $display("FAIL rot_ctl_seq got ctl=%b de=%b want ctl=%b de=0", ctl, de, c + 2'd1);
      end
      c = c + 2'd1;
    end
  endtask

  task automatic test_async_reset();
    int n;
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b0 || offset !== 4'd0 || de !== 1'b0 || ctl !== 2'd0 || dout !== 8'd0) begin
      errors++; $display("FAIL async_reset got locked=%b offset=%0d de=%b ctl=%b dout=%h want all 0",
                         locked, offset, de, ctl, dout);
    end
`ifdef CV_TMDS_DECODER_ERRCNT_EN
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL async_errcnt got %0d want 0", err_cnt); end
`endif
    @(posedge clk);
    #1;
    resetn   = 1'b1;
    last_sym = 10'd0;
    n = 0;
    while (!locked && n < 100) begin
      step(T0, 0);
      n++;
    end
    checks++; if (n !== 18) begin errors++; $display("FAIL relock_cycles got %0d want 18", n); end
    checks++; if (offset !== 4'd0) begin errors++; $display("FAIL relock_offset got %0d want 0", offset); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    resetn   = 1'b0;
    din      = 10'd0;
    last_sym = 10'd0;
    test_reset();
    test_aligned_lock();
    test_data_decode();
    test_token_loss();
    test_wrap();
    test_rotated();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
